// File: rtl/io_pins_cmd_engine_if.sv
// Host-side byte link between the deframer (master) and the command engine (slave).
// RX carries command/payload bytes in, TX carries response bytes out; both are valid/ready.
interface io_pins_cmd_engine_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output rx_data, rx_valid, tx_ready,
        input  rx_ready, tx_data, tx_valid
    );

    modport slave (
        input  rx_data, rx_valid, tx_ready,
        output rx_ready, tx_data, tx_valid
    );
endinterface

// File: rtl/io_pins_cmd_engine.sv
// Byte-stream command engine: WRITE commits a full pin image atomically, READ returns a pin snapshot.
// Image visible 1 cycle after last payload byte; rx stalls outside IDLE/WR_LOAD, tx holds until tx_ready.
module io_pins_cmd_engine #(
    parameter int PINS_CONT   = 132,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                 CLK50,
    input  logic                 rst_n,
    io_pins_cmd_engine_if.slave  host,
    output logic                 write_enable,
    output logic [7:0]           output_pins_state [0:(PINS_CONT+7)/8-1],
    input  logic [7:0]           input_pins_state  [0:(PINS_CONT+7)/8-1],
    output logic                 busy,
    output logic                 err_pulse
);
    localparam int NBYTES = (PINS_CONT + 7) / 8;
    localparam int CW     = $clog2(NBYTES + 1);
    localparam int TW     = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CW-1:0] LAST_IDX = CW'(NBYTES - 1);
    localparam logic [CW-1:0] NB_CNT   = CW'(NBYTES);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);

    localparam logic [7:0] OP_WRITE   = 8'hA5;
    localparam logic [7:0] OP_READ    = 8'h5A;
    localparam logic [7:0] OP_RELEASE = 8'hF0;
    localparam logic [7:0] RSP_HDR    = 8'h5A;
    localparam logic [7:0] RSP_ERR    = 8'hEE;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WR_LOAD   = 3'd1;
    localparam logic [2:0] S_WR_COMMIT = 3'd2;
    localparam logic [2:0] S_RD_SNAP   = 3'd3;
    localparam logic [2:0] S_RD_SEND   = 3'd4;
    localparam logic [2:0] S_ERR_RSP   = 3'd5;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [TW-1:0] idle_cnt;
    logic [7:0]    shadow   [0:NBYTES-1];
    logic [7:0]    snapshot [0:NBYTES-1];
    logic [7:0]    tx_dat_q;
    logic          tx_vld_q;
    logic          rx_rdy;
    logic          rx_fire;
    logic          tx_fire;

    // Clears bits of the last byte that map past the physical pin count.
    function automatic logic [7:0] pin_mask(input int idx);
        logic [7:0] m;
        for (int j = 0; j < 8; j++) begin
            m[j] = ((idx * 8 + j) < PINS_CONT);
        end
        return m;
    endfunction

    assign rx_rdy        = (state == S_IDLE) || (state == S_WR_LOAD);
    assign rx_fire       = host.rx_valid & rx_rdy;
    assign tx_fire       = tx_vld_q & host.tx_ready;
    assign host.rx_ready = rx_rdy;
    assign host.tx_valid = tx_vld_q;
    assign host.tx_data  = tx_dat_q;
    assign busy          = (state != S_IDLE);

    always_ff @(posedge CLK50 or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            cnt          <= '0;
            idle_cnt     <= '0;
            write_enable <= 1'b0;
            tx_vld_q     <= 1'b0;
            tx_dat_q     <= 8'h00;
            err_pulse    <= 1'b0;
            for (int i = 0; i < NBYTES; i++) begin
                output_pins_state[i] <= 8'h00;
                shadow[i]            <= 8'h00;
                snapshot[i]          <= 8'h00;
            end
        end else begin
            err_pulse <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rx_fire) begin
                        case (host.rx_data)
                            OP_WRITE: begin
                                state    <= S_WR_LOAD;
                                cnt      <= '0;
                                idle_cnt <= '0;
                            end
                            OP_READ: begin
                                // Reading while driving would return our own image, so refuse.
                                if (write_enable) begin
                                    state     <= S_ERR_RSP;
                                    tx_vld_q  <= 1'b1;
                                    tx_dat_q  <= RSP_ERR;
                                    err_pulse <= 1'b1;
                                end else begin
                                    state <= S_RD_SNAP;
                                end
                            end
                            OP_RELEASE: write_enable <= 1'b0;
                            default:    err_pulse    <= 1'b1;
                        endcase
                    end
                end
                S_WR_LOAD: begin
                    if (rx_fire) begin
                        shadow[cnt] <= host.rx_data;
                        idle_cnt    <= '0;
                        if (cnt == LAST_IDX) begin
                            state <= S_WR_COMMIT;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else if (idle_cnt == TO_LAST) begin
                        state     <= S_IDLE;
                        err_pulse <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                S_WR_COMMIT: begin
                    for (int i = 0; i < NBYTES; i++) begin
                        output_pins_state[i] <= shadow[i] & pin_mask(i);
                    end
                    write_enable <= 1'b1;
                    state        <= S_IDLE;
                end
                S_RD_SNAP: begin
                    for (int i = 0; i < NBYTES; i++) begin
                        snapshot[i] <= input_pins_state[i] & pin_mask(i);
                    end
                    tx_vld_q <= 1'b1;
                    tx_dat_q <= RSP_HDR;
                    cnt      <= '0;
                    state    <= S_RD_SEND;
                end
                S_RD_SEND: begin
                    // cnt = number of snapshot bytes already presented after the header.
                    if (tx_fire) begin
                        if (cnt == NB_CNT) begin
                            tx_vld_q <= 1'b0;
                            state    <= S_IDLE;
                        end else begin
                            tx_dat_q <= snapshot[cnt];
                            cnt      <= cnt + 1'b1;
                        end
                    end
                end
                S_ERR_RSP: begin
                    if (tx_fire) begin
                        tx_vld_q <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_io_pins_cmd_engine.sv
// Directed bench for io_pins_cmd_engine: write/commit, read with stalls, error paths, timeout, reset.
module tb_io_pins_cmd_engine;
    localparam int PINS = 132;
    localparam int NB   = 17;
    localparam int TO   = 40;

    logic       CLK50 = 1'b0;
    logic       rst_n;
    logic       write_enable;
    logic       busy;
    logic       err_pulse;
    logic [7:0] out_img [0:NB-1];
    logic [7:0] in_img  [0:NB-1];

    int total = 0;
    int bad   = 0;

    io_pins_cmd_engine_if bus ();

    io_pins_cmd_engine #(.PINS_CONT(PINS), .TIMEOUT_CYC(TO)) dut (
        .CLK50             (CLK50),
        .rst_n             (rst_n),
        .host              (bus),
        .write_enable      (write_enable),
        .output_pins_state (out_img),
        .input_pins_state  (in_img),
        .busy              (busy),
        .err_pulse         (err_pulse)
    );

    always #5 CLK50 = ~CLK50;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents a byte at a negedge and returns at the negedge after it is accepted.
    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (bus.rx_ready !== 1'b1 && t < 100) begin
            @(negedge CLK50);
            t++;
        end
        if (t >= 100) chk("rx_accept_timeout", 8'(t), 8'd0);
        @(negedge CLK50);
        bus.rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) @(negedge CLK50);
    endtask

    // Optionally stalls one cycle, checking the byte holds, then takes it.
    task automatic expect_tx(input string tag, input logic [7:0] exp, input bit stall);
        int t = 0;
        while (bus.tx_valid !== 1'b1 && t < 100) begin
            @(negedge CLK50);
            t++;
        end
        chk({tag, "_vld"}, 8'(bus.tx_valid), 8'd1);
        if (stall) begin
            bus.tx_ready = 1'b0;
            @(negedge CLK50);
            chk({tag, "_stall_vld"}, 8'(bus.tx_valid), 8'd1);
            chk({tag, "_stall_dat"}, bus.tx_data, exp);
        end
        chk(tag, bus.tx_data, exp);
        bus.tx_ready = 1'b1;
        @(negedge CLK50);
        bus.tx_ready = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b0;
        for (int i = 0; i < NB; i++) in_img[i] = 8'h00;
        idle(3);
        rst_n = 1'b1;
        idle(2);

        // 1: reset state, then reset in the middle of a WRITE
        chk("rst_we",    8'(write_enable), 8'd0);
        chk("rst_busy",  8'(busy),         8'd0);
        chk("rst_rdy",   8'(bus.rx_ready), 8'd1);
        chk("rst_txv",   8'(bus.tx_valid), 8'd0);
        chk("rst_txd",   bus.tx_data,      8'h00);
        chk("rst_err",   8'(err_pulse),    8'd0);
        chk("rst_img0",  out_img[0],       8'h00);
        send_byte(8'hA5);
        send_byte(8'h77);
        send_byte(8'h66);
        chk("mid_busy",  8'(busy),         8'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 8'(busy),         8'd0);
        chk("arst_rdy",  8'(bus.rx_ready), 8'd1);
        chk("arst_img0", out_img[0],       8'h00);
        chk("arst_we",   8'(write_enable), 8'd0);
        @(negedge CLK50);
        rst_n = 1'b1;
        idle(1);

        // 2: WRITE 0x00..0x10 with gaps; byte 16 upper nibble masked
        send_byte(8'hA5);
        for (int i = 0; i < NB; i++) begin
            send_byte(8'(i));
            if (i < NB - 1) idle(i % 3);
        end
        chk("wr_pre_img5",  out_img[5],       8'h00);
        chk("wr_pre_we",    8'(write_enable), 8'd0);
        chk("wr_pre_busy",  8'(busy),         8'd1);
        @(negedge CLK50);
        for (int i = 0; i < NB - 1; i++) chk($sformatf("wr_img%0d", i), out_img[i], 8'(i));
        chk("wr_img16",  out_img[16],      8'h00);
        chk("wr_we",     8'(write_enable), 8'd1);
        chk("wr_busy",   8'(busy),         8'd0);

        // 3: RELEASE, then READ with alternating stalls and a blocked rx byte
        send_byte(8'hF0);
        chk("rel_we",   8'(write_enable), 8'd0);
        chk("rel_busy", 8'(busy),         8'd0);
        for (int i = 0; i < NB; i++) in_img[i] = 8'hC0 + 8'(i);
        send_byte(8'h5A);
        expect_tx("rd_hdr", 8'h5A, 1'b1);
        for (int i = 0; i < NB; i++) begin
            if (i == 4) begin
                bus.rx_data  = 8'h33;
                bus.rx_valid = 1'b1;
            end
            if (i == 10) begin
                chk("rd_rx_blocked", 8'(bus.rx_ready), 8'd0);
                chk("rd_rx_no_err",  8'(err_pulse),    8'd0);
                bus.rx_valid = 1'b0;
            end
            expect_tx($sformatf("rd_b%0d", i), (i == NB - 1) ? 8'h00 : 8'hC0 + 8'(i), i[0]);
        end
        chk("rd_end_txv",  8'(bus.tx_valid), 8'd0);
        chk("rd_end_busy", 8'(busy),         8'd0);
        chk("rd_end_err",  8'(err_pulse),    8'd0);
        chk("rd_img3",     out_img[3],       8'h03);

        // 4: WRITE 0x1F-i (byte 16 = 0x0F kept), then READ while driving -> 0xEE
        send_byte(8'hA5);
        for (int i = 0; i < NB; i++) send_byte(8'h1F - 8'(i));
        @(negedge CLK50);
        chk("wr2_img0",  out_img[0],       8'h1F);
        chk("wr2_img16", out_img[16],      8'h0F);
        chk("wr2_we",    8'(write_enable), 8'd1);
        send_byte(8'h5A);
        chk("erd_err",   8'(err_pulse),    8'd1);
        chk("erd_txv",   8'(bus.tx_valid), 8'd1);
        chk("erd_txd",   bus.tx_data,      8'hEE);
        @(negedge CLK50);
        chk("erd_err_1cyc", 8'(err_pulse), 8'd0);
        expect_tx("erd_rsp", 8'hEE, 1'b1);
        chk("erd_txv_off", 8'(bus.tx_valid), 8'd0);
        chk("erd_busy",    8'(busy),         8'd0);
        idle(3);
        chk("erd_single",  8'(bus.tx_valid), 8'd0);
        chk("erd_img16",   out_img[16],      8'h0F);

        // 5: partial WRITE then silence -> timeout after TO idle cycles
        send_byte(8'hA5);
        for (int i = 0; i < 5; i++) send_byte(8'h55);
        idle(TO - 1);
        chk("to_pre_busy", 8'(busy),      8'd1);
        chk("to_pre_err",  8'(err_pulse), 8'd0);
        @(negedge CLK50);
        chk("to_err",      8'(err_pulse), 8'd1);
        chk("to_busy",     8'(busy),      8'd0);
        @(negedge CLK50);
        chk("to_err_1cyc", 8'(err_pulse),    8'd0);
        chk("to_img0",     out_img[0],       8'h1F);
        chk("to_img4",     out_img[4],       8'h1B);
        chk("to_we",       8'(write_enable), 8'd1);

        // 6: unknown opcode, then a normal WRITE
        send_byte(8'h33);
        chk("unk_err",  8'(err_pulse),    8'd1);
        chk("unk_txv",  8'(bus.tx_valid), 8'd0);
        chk("unk_busy", 8'(busy),         8'd0);
        @(negedge CLK50);
        chk("unk_err_1cyc", 8'(err_pulse), 8'd0);
        send_byte(8'hA5);
        for (int i = 0; i < NB; i++) send_byte(8'hA0 + 8'(i));
        @(negedge CLK50);
        chk("wr3_img7",  out_img[7],  8'hA7);
        chk("wr3_img15", out_img[15], 8'hAF);
        chk("wr3_img16", out_img[16], 8'h00);
        chk("wr3_busy",  8'(busy),    8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
